bit_reverse_tx: RTL

//   Downstream stage of the message memory. Captures an assembled message byte,
//   bit-reverses it, and streams it out as ASCII '1'/'0' characters.
//   The characters go over a valid/ready handshake to the character transmitter.

---
 rtl/bit_reverse_tx.sv | 90 +++++++++
 1 files changed

// File: rtl/bit_reverse_tx.sv
// bit_reverse_tx: captures a message byte, bit-reverses it and streams it as ASCII '1'/'0' characters
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous active-low reset
//   byte_in    - assembled message byte (NBITS wide)
//   load       - capture request, honoured only while idle
//   busy       - high whenever a message is in progress (state != IDLE)
//   char_out   - ASCII character to the transmitter, 8'h00 when not valid
//   char_valid - char_out holds a valid character
//   char_ready - transmitter accepts char_out this cycle
//   done       - one-cycle pulse after the last character is accepted
//
// Build option: define LINE_TERM_EN to append CR (8'h0D) and LF (8'h0A) after the bit characters.
module bit_reverse_tx #(
   parameter int         NBITS     = 8,
   parameter logic [7:0] CHAR_ONE  = 8'h31,
   parameter logic [7:0] CHAR_ZERO = 8'h30
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NBITS-1:0] byte_in,
   input  logic             load,
   output logic             busy,
   output logic [7:0]       char_out,
   output logic             char_valid,
   input  logic             char_ready,
   output logic             done
);
   localparam int IW = $clog2(NBITS);
   localparam logic [IW-1:0] LAST = IW'(NBITS - 1);
   typedef enum logic [1:0] {IDLE, SEND, TERM, DONE} state_t;
   state_t state, state_nxt;
   logic [NBITS-1:0] shreg, rev;
   logic [IW-1:0] idx;
   logic xfer, last_bit, term_last;
   assign xfer     = char_valid & char_ready;
   assign last_bit = idx == LAST;
   always_comb begin
      rev = '0;
      for (int i = 0; i < NBITS; i++) rev[i] = byte_in[NBITS-1-i];
   end
`ifdef LINE_TERM_EN
   // term_sel = 0 while CR is offered, 1 while LF is offered
   logic term_sel;
   assign term_last = term_sel;
   always_ff @(posedge clk or negedge reset)
      if (!reset) term_sel <= 1'b0;
      else if (state != TERM) term_sel <= 1'b0;
      else if (xfer) term_sel <= 1'b1;
`else
   assign term_last = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = load ? SEND : IDLE;
`ifdef LINE_TERM_EN
         SEND: state_nxt = (xfer && last_bit) ? TERM : SEND;
`else
         SEND: state_nxt = (xfer && last_bit) ? DONE : SEND;
`endif
         TERM: state_nxt = (xfer && term_last) ? DONE : TERM;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   // The head bit sits at the MSB of shreg; idx stops at LAST so it never wraps
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         shreg <= '0;
         idx   <= '0;
      end else if (state == IDLE && load) begin
         shreg <= rev;
         idx   <= '0;
      end else if (state == SEND && xfer) begin
         shreg <= shreg << 1;
         idx   <= last_bit ? idx : idx + IW'(1);
      end
   always_comb begin
      busy       = state != IDLE;
      done       = state == DONE;
      char_valid = state == SEND || state == TERM;
      char_out   = state == SEND ? (shreg[NBITS-1] ? CHAR_ONE : CHAR_ZERO) :
                   state == TERM ? (term_last ? 8'h0A : 8'h0D) : 8'h00;
   end
endmodule
